// File: rtl/mem_stage.sv
// Memory stage: multi-cycle access to an internal word-addressed data memory,
// stalling upstream with freeze and driving the MEM/WB pipeline register.
module mem_stage #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ST_val_in,
  input  logic [4:0]  Dest_in,
  output logic        freeze,
  output logic        WB_en,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_result,
  output logic [31:0] MEM_result,
  output logic [4:0]  Dest,
  output logic        addr_err,
  output logic        state_dbg
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0]  CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              wb_en_q, mem_r_en_q, addr_err_q;
  logic [31:0]       alu_result_q, mem_result_q;
  logic [4:0]        dest_q;
  logic [31:0]       mem_q [DEPTH];

  logic              req, is_load, in_range, complete, mem_we;
  logic [29:0]       word_off;
  logic [IDX_W-1:0]  idx;
  logic              mem_r_en_d, addr_err_d;
  logic [31:0]       mem_result_d;

  // Word offset from the base; the low two address bits never select a word.
  assign word_off = ALU_result_in[31:2] - BASE_ADDR[31:2];
  assign in_range = (ALU_result_in[31:2] >= BASE_ADDR[31:2]) && (word_off < 30'(DEPTH));
  assign idx      = word_off[IDX_W-1:0];
  assign req      = MEM_R_EN_in | MEM_W_EN_in;
  assign is_load  = MEM_R_EN_in & ~MEM_W_EN_in;

  assign complete = req && ((state_q == S_IDLE) ? !HAS_WAIT : (cnt_q == 4'd0));
  // Gating with rst keeps freeze low and blocks the write while reset is held.
  assign freeze   = rst && req && !complete;
  assign mem_we   = rst && complete && MEM_W_EN_in && in_range;

  always_comb begin
    mem_r_en_d   = is_load;
    addr_err_d   = req && !in_range;
    mem_result_d = (is_load && in_range) ? mem_q[idx] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= ST_val_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      alu_result_q <= 32'd0;
      mem_result_q <= 32'd0;
      dest_q       <= 5'd0;
    end else begin
      if ((state_q == S_IDLE && req && HAS_WAIT) ||
          (state_q == S_WAIT && cnt_q != 4'd0)) begin
        // Stall cycle: bubble into MEM/WB, data fields hold.
        state_q    <= S_WAIT;
        cnt_q      <= (state_q == S_IDLE) ? CNT_INIT : cnt_q - 4'd1;
        wb_en_q    <= 1'b0;
        mem_r_en_q <= 1'b0;
        addr_err_q <= 1'b0;
      end else begin
        state_q      <= S_IDLE;
        cnt_q        <= 4'd0;
        wb_en_q      <= WB_en_in;
        mem_r_en_q   <= mem_r_en_d;
        addr_err_q   <= addr_err_d;
        alu_result_q <= ALU_result_in;
        mem_result_q <= mem_result_d;
        dest_q       <= Dest_in;
      end
    end
  end

  assign WB_en      = wb_en_q;
  assign MEM_R_EN   = mem_r_en_q;
  assign ALU_result = alu_result_q;
  assign MEM_result = mem_result_q;
  assign Dest       = dest_q;
  assign addr_err   = addr_err_q;
  assign state_dbg  = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random loads/stores checked against a
// word-array memory model; a second instance covers the single-cycle build.
module tb_mem_stage;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          WAITC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rst0;
  logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_result_in, ST_val_in;
  logic [4:0]  Dest_in;

  logic        f2, wb2, rd2, err2, st2;
  logic [31:0] alu2, res2;
  logic [4:0]  dst2;
  logic        f0, wb0, rd0, err0, st0;
  logic [31:0] alu0, res0;
  logic [4:0]  dst0;

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst2), .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
    .MEM_W_EN_in(MEM_W_EN_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
    .Dest_in(Dest_in), .freeze(f2), .WB_en(wb2), .MEM_R_EN(rd2), .ALU_result(alu2),
    .MEM_result(res2), .Dest(dst2), .addr_err(err2), .state_dbg(st2));

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
    .MEM_W_EN_in(MEM_W_EN_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
    .Dest_in(Dest_in), .freeze(f0), .WB_en(wb0), .MEM_R_EN(rd0), .ALU_result(alu0),
    .MEM_result(res0), .Dest(dst0), .addr_err(err0), .state_dbg(st0));

  bit          use0 = 1'b0;
  logic        o_freeze, o_wb, o_rd, o_err;
  logic [31:0] o_alu, o_res;
  logic [4:0]  o_dst;

  always_comb begin
    o_freeze = use0 ? f0   : f2;
    o_wb     = use0 ? wb0  : wb2;
    o_rd     = use0 ? rd0  : rd2;
    o_err    = use0 ? err0 : err2;
    o_alu    = use0 ? alu0 : alu2;
    o_res    = use0 ? res0 : res2;
    o_dst    = use0 ? dst0 : dst2;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  int          known_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned la = a;
    return (la >= BASE) && (((la - BASE) / 4) < DEPTH);
  endfunction

  // One complete pipeline transaction: drive, follow every cycle, check result.
  task automatic access(input bit r, input bit w, input logic [31:0] addr,
                        input logic [31:0] val, input logic [4:0] dest,
                        input bit wben, input string tag);
    bit          req, inr;
    int          lat, idx;
    logic [31:0] exp_res;
    req = r | w;
    inr = addr_ok(addr);
    idx = inr ? int'((addr - BASE) / 4) : 0;
    lat = req ? (use0 ? 0 : WAITC) : 0;
    MEM_R_EN_in = r; MEM_W_EN_in = w; ALU_result_in = addr;
    ST_val_in = val; Dest_in = dest; WB_en_in = wben;
    for (int k = 0; k <= lat; k++) begin
      #1;
      chk({tag, ".freeze"}, {31'b0, o_freeze}, {31'b0, (k < lat)});
      @(posedge clk); #1;
      if (k < lat) begin
        chk({tag, ".bub_wb"}, {31'b0, o_wb}, 32'd0);
        chk({tag, ".bub_rd"}, {31'b0, o_rd}, 32'd0);
        chk({tag, ".bub_err"}, {31'b0, o_err}, 32'd0);
      end
    end
    exp_res = (r && !w && inr) ? model_mem[idx] : 32'd0;
    chk({tag, ".wb"},   {31'b0, o_wb},  {31'b0, wben});
    chk({tag, ".rd"},   {31'b0, o_rd},  {31'b0, (r && !w)});
    chk({tag, ".alu"},  o_alu,          addr);
    chk({tag, ".res"},  o_res,          exp_res);
    chk({tag, ".dest"}, {27'b0, o_dst}, {27'b0, dest});
    chk({tag, ".err"},  {31'b0, o_err}, {31'b0, (req && !inr)});
    if (w && inr) begin
      model_mem[idx] = val;
      known_q.push_back(idx);
    end
  endtask

  task automatic idle_inputs();
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_en_in = 1'b0;
    ALU_result_in = 32'd0; ST_val_in = 32'd0; Dest_in = 5'd0;
  endtask

  task automatic random_ops(input int n, input string tag);
    int          op, ki;
    bit          oor;
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      op  = int'($urandom_range(0, 3));
      oor = ($urandom_range(0, 4) == 0);
      if (oor)
        addr = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 100))
                                           : BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000));
      else
        addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      if (op == 1 && !oor) begin
        if (known_q.size() == 0) addr = BASE - 32'd4;
        else begin
          ki   = int'($urandom_range(0, known_q.size() - 1));
          addr = BASE + 32'(4 * known_q[ki]) + 32'($urandom_range(0, 3));
        end
      end
      access(op == 1 || op == 3, op >= 2, addr, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), tag);
    end
  endtask

  initial begin
    rst2 = 1'b0; rst0 = 1'b0;
    idle_inputs();
    MEM_W_EN_in = 1'b1; ALU_result_in = 32'd1028;
    #12;
    chk("rst.freeze", {31'b0, o_freeze}, 32'd0);
    chk("rst.wb",     {31'b0, o_wb},     32'd0);
    chk("rst.rd",     {31'b0, o_rd},     32'd0);
    chk("rst.alu",    o_alu,             32'd0);
    chk("rst.res",    o_res,             32'd0);
    chk("rst.dest",   {27'b0, o_dst},    32'd0);
    chk("rst.err",    {31'b0, o_err},    32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst2 = 1'b1;

    access(0, 1, 32'd1028, 32'hDEADBEEF, 5'd3, 1'b0, "t1_store");
    access(1, 0, 32'd1028, 32'd0, 5'd9, 1'b1, "t2_load");
    access(0, 0, 32'h55, 32'd0, 5'd7, 1'b1, "t3_alu");
    access(1, 1, 32'd1029, 32'h0BADF00D, 5'd4, 1'b1, "both_store");
    access(1, 0, 32'd1028, 32'd0, 5'd5, 1'b1, "both_load");

    access(0, 1, BASE, 32'hA0A0A0A0, 5'd1, 1'b0, "pre_w0");
    access(0, 1, BASE + 32'(4 * (DEPTH - 1)), 32'hB1B1B1B1, 5'd1, 1'b0, "pre_wlast");
    access(1, 0, 32'd1020, 32'd0, 5'd2, 1'b1, "t4_ld_low");
    access(1, 0, BASE + 32'(4 * DEPTH), 32'd0, 5'd2, 1'b1, "t4_ld_high");
    access(0, 1, 32'd1020, 32'h12345678, 5'd2, 1'b0, "t4_st_low");
    access(0, 1, BASE + 32'(4 * DEPTH), 32'h87654321, 5'd2, 1'b0, "t4_st_high");
    access(1, 0, BASE, 32'd0, 5'd6, 1'b1, "t4_chk_w0");
    access(1, 0, BASE + 32'(4 * (DEPTH - 1)), 32'd0, 5'd6, 1'b1, "t4_chk_wlast");
    access(1, 0, 32'd1028, 32'd0, 5'd6, 1'b1, "t4_chk_w1");

    access(0, 1, 32'd1032, 32'h11112222, 5'd8, 1'b0, "t5_pre");
    MEM_W_EN_in = 1'b1; ALU_result_in = 32'd1032; ST_val_in = 32'h33334444;
    Dest_in = 5'd8; WB_en_in = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    #1;
    chk("t5.freeze", {31'b0, o_freeze}, 32'd0);
    chk("t5.wb",     {31'b0, o_wb},     32'd0);
    chk("t5.alu",    o_alu,             32'd0);
    chk("t5.res",    o_res,             32'd0);
    chk("t5.dest",   {27'b0, o_dst},    32'd0);
    @(posedge clk); #1;
    idle_inputs();
    rst2 = 1'b1;
    access(1, 0, 32'd1032, 32'd0, 5'd10, 1'b1, "t5_mem2");

    random_ops(40, "rnd");

    rst2 = 1'b0;
    use0 = 1'b1;
    known_q.delete();
    rst0 = 1'b1;
    access(0, 1, 32'd1036, 32'hCAFEF00D, 5'd11, 1'b0, "t6_store");
    access(1, 0, 32'd1036, 32'd0, 5'd12, 1'b1, "t6_load");
    random_ops(20, "rnd0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
